// File: rtl/mem_pipe_unit.sv
// mem_pipe_unit: memory stage with a multi-cycle data memory access and a WB output register.
// Optional feature: define MEM_FWD_EN to add a last-store register that lets a
// read of the most recently stored address complete in one cycle.
module mem_pipe_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              mem_to_reg,
    input  logic              reg_to_mem,
    input  logic [REG_W-1:0]  reg_rd_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic              ret_future_in,
    output logic              stall,
    output logic              valid_out,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  reg_rd_out,
    output logic              ret_future_out,
    output logic              mem_to_reg_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [CW-1:0]     lat_cnt, lat_cnt_nxt;
    logic              done;
    logic              load;
    logic              stall_raw;

    // op held while the memory access is in progress
    logic [DATA_W-1:0] op_alu, op_wdata;
    logic [REG_W-1:0]  op_rd;
    logic              op_m2r, op_r2m, op_ret;

    // the op completing this cycle (from the inputs in IDLE, from the latch in BUSY)
    logic [DATA_W-1:0] c_alu, c_wdata;
    logic [REG_W-1:0]  c_rd;
    logic              c_m2r, c_r2m, c_ret;
    logic [AW-1:0]     c_addr;

    logic              in_mem, in_fwd, in_fast;
    logic              mem_we;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_FWD_EN
    logic [AW-1:0]     st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_vld;

    // a pure read hitting the last stored address is served from the store register
    assign in_fwd = st_vld && mem_to_reg && !reg_to_mem && (st_addr == alu_result[AW-1:0]);
`else
    assign in_fwd = 1'b0;
`endif

    assign in_mem  = mem_to_reg | reg_to_mem;
    assign in_fast = !in_mem || (MEM_LAT == 1) || in_fwd;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // next state, completion select and stall
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        done        = 1'b0;
        load        = 1'b0;
        stall_raw   = 1'b0;
        c_alu       = alu_result;
        c_wdata     = mem_write_data;
        c_rd        = reg_rd_in;
        c_m2r       = mem_to_reg;
        c_r2m       = reg_to_mem;
        c_ret       = ret_future_in;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (in_fast) begin
                        done = 1'b1;
                    end else begin
                        load        = 1'b1;
                        stall_raw   = 1'b1;
                        state_nxt   = BUSY;
                        lat_cnt_nxt = CW'(MEM_LAT - 1);
                    end
                end
            end
            BUSY: begin
                c_alu     = op_alu;
                c_wdata   = op_wdata;
                c_rd      = op_rd;
                c_m2r     = op_m2r;
                c_r2m     = op_r2m;
                c_ret     = op_ret;
                stall_raw = valid_in && (lat_cnt != CW'(1));
                if (lat_cnt == CW'(1)) begin
                    done        = 1'b1;
                    state_nxt   = IDLE;
                    lat_cnt_nxt = '0;
                end else begin
                    lat_cnt_nxt = lat_cnt - CW'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                lat_cnt_nxt = '0;
            end
        endcase
    end

    assign stall  = stall_raw & ~rst;
    assign c_addr = c_alu[AW-1:0];
    assign mem_we = done & c_r2m & ~rst;

`ifdef MEM_FWD_EN
    assign rd_word = ((state == IDLE) && in_fwd) ? st_data : mem[c_addr];
`else
    assign rd_word = mem[c_addr];
`endif

    // capture the accepted op so the access does not depend on held inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_alu   <= '0;
            op_wdata <= '0;
            op_rd    <= '0;
            op_m2r   <= 1'b0;
            op_r2m   <= 1'b0;
            op_ret   <= 1'b0;
        end else if (load) begin
            op_alu   <= alu_result;
            op_wdata <= mem_write_data;
            op_rd    <= reg_rd_in;
            op_m2r   <= mem_to_reg;
            op_r2m   <= reg_to_mem;
            op_ret   <= ret_future_in;
        end
    end

    // data memory, written once on the completion edge, never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[c_addr] <= c_wdata;
        end
    end

`ifdef MEM_FWD_EN
    // last-store register for read forwarding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_addr <= '0;
            st_data <= '0;
            st_vld  <= 1'b0;
        end else if (done && c_r2m) begin
            st_addr <= c_addr;
            st_data <= c_wdata;
            st_vld  <= 1'b1;
        end
    end
`endif

    // WB register: loads on completion, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out      <= 1'b0;
            mem_read_data  <= '0;
            alu_result_out <= '0;
            reg_rd_out     <= '0;
            ret_future_out <= 1'b0;
            mem_to_reg_out <= 1'b0;
        end else begin
            valid_out <= done;
            if (done) begin
                mem_read_data  <= (c_m2r && !c_r2m) ? rd_word : '0;
                alu_result_out <= c_alu;
                reg_rd_out     <= c_rd;
                ret_future_out <= c_ret;
                mem_to_reg_out <= c_m2r;
            end
        end
    end

endmodule
